// File: rtl/parking_slot_alloc16.sv
// 16-slot parking allocator: grants the lowest free slot on entry, frees the named
// slot on exit, and holds the entry gate open for GATE_CYCLES cycles after a grant.
module parking_slot_alloc16 #(
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        entry_req,
  input  logic        exit_req,
  input  logic [3:0]  exit_slot,
  output logic        entry_ack,
  output logic [3:0]  entry_slot,
  output logic        entry_reject,
  output logic        exit_ack,
  output logic        exit_err,
  output logic        gate_open,
  output logic [15:0] slots,
  output logic [4:0]  occupied_count,
  output logic        all_full,
  output logic        any_free
);

  typedef enum logic {IDLE, OPEN} state_t;

  localparam logic [7:0] GATE_LOAD = 8'(GATE_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] slots_q, slots_d;
  logic [4:0]  count_q, count_d;
  logic [3:0]  entry_slot_q, entry_slot_d;
  logic        entry_ack_q, entry_ack_d;
  logic        entry_reject_q, entry_reject_d;
  logic        exit_ack_q, exit_ack_d;
  logic        exit_err_q, exit_err_d;
  logic        gate_open_q, gate_open_d;
  logic        all_full_q, any_free_q;
  logic        free_found;
  logic [3:0]  free_idx;

  // NOTE: every always_comb output is given a default first so no path infers a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    slots_d        = slots_q;
    entry_slot_d   = entry_slot_q;
    entry_ack_d    = 1'b0;
    entry_reject_d = 1'b0;
    exit_ack_d     = 1'b0;
    exit_err_d     = 1'b0;
    free_found     = 1'b0;
    free_idx       = 4'd0;

    // Scan downward so the last hit left standing is the lowest free index.
    for (int i = 15; i >= 0; i--) begin
      if (!slots_q[i]) begin
        free_found = 1'b1;
        free_idx   = 4'(i);
      end
    end

    case (state_q)
      IDLE: begin
        if (entry_req) begin
          if (free_found) begin
            slots_d[free_idx] = 1'b1;
            entry_slot_d      = free_idx;
            entry_ack_d       = 1'b1;
            state_d           = OPEN;
            cnt_d             = GATE_LOAD;
          end else begin
            entry_reject_d = 1'b1;
          end
        end
      end
      OPEN: begin
        if (cnt_q == 8'd1) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Exit only touches an occupied bit and entry only a free one, so both can apply.
    if (exit_req) begin
      if (slots_q[exit_slot]) begin
        slots_d[exit_slot] = 1'b0;
        exit_ack_d         = 1'b1;
      end else begin
        exit_err_d = 1'b1;
      end
    end

    count_d = 5'd0;
    for (int i = 0; i < 16; i++) begin
      count_d = count_d + 5'(slots_d[i]);
    end

    gate_open_d = (state_d == OPEN);
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      slots_q        <= 16'd0;
      count_q        <= 5'd0;
      entry_slot_q   <= 4'd0;
      entry_ack_q    <= 1'b0;
      entry_reject_q <= 1'b0;
      exit_ack_q     <= 1'b0;
      exit_err_q     <= 1'b0;
      gate_open_q    <= 1'b0;
      all_full_q     <= 1'b0;
      any_free_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      slots_q        <= slots_d;
      count_q        <= count_d;
      entry_slot_q   <= entry_slot_d;
      entry_ack_q    <= entry_ack_d;
      entry_reject_q <= entry_reject_d;
      exit_ack_q     <= exit_ack_d;
      exit_err_q     <= exit_err_d;
      gate_open_q    <= gate_open_d;
      all_full_q     <= &slots_d;
      any_free_q     <= ~&slots_d;
    end
  end

  assign entry_ack      = entry_ack_q;
  assign entry_slot     = entry_slot_q;
  assign entry_reject   = entry_reject_q;
  assign exit_ack       = exit_ack_q;
  assign exit_err       = exit_err_q;
  assign gate_open      = gate_open_q;
  assign slots          = slots_q;
  assign occupied_count = count_q;
  assign all_full       = all_full_q;
  assign any_free       = any_free_q;

endmodule

// File: tb/tb_parking_slot_alloc16.sv
// Scoreboard bench for parking_slot_alloc16: directed requests push expected
// responses; a monitor pops and compares whenever a response pulse appears.
module tb_parking_slot_alloc16;

  logic        clk = 1'b0;
  logic        rst;
  logic        entry_req, exit_req;
  logic [3:0]  exit_slot;
  logic        entry_ack, entry_reject, exit_ack, exit_err, gate_open;
  logic [3:0]  entry_slot;
  logic [15:0] slots;
  logic [4:0]  occupied_count;
  logic        all_full, any_free;

  parking_slot_alloc16 #(.GATE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .entry_req(entry_req), .exit_req(exit_req), .exit_slot(exit_slot),
    .entry_ack(entry_ack), .entry_slot(entry_slot), .entry_reject(entry_reject),
    .exit_ack(exit_ack), .exit_err(exit_err), .gate_open(gate_open),
    .slots(slots), .occupied_count(occupied_count),
    .all_full(all_full), .any_free(any_free)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ea;
    logic [3:0]  es;
    logic        er;
    logic        xa;
    logic        xe;
    logic [15:0] sl;
    logic [4:0]  cnt;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic expect_resp(input logic ea, input logic [3:0] es, input logic er,
                             input logic xa, input logic xe,
                             input logic [15:0] sl, input logic [4:0] cnt);
    exp_t e;
    e.ea = ea; e.es = es; e.er = er; e.xa = xa; e.xe = xe;
    e.sl = sl; e.cnt = cnt; e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic wait_gate_closed();
    int n = 0;
    while (gate_open && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("gate_close_timeout", {31'd0, gate_open}, 32'd0);
  endtask

  // One request cycle; on a grant, wait for the gate to close before returning.
  task automatic issue(input logic e, input logic x, input logic [3:0] xs,
                       input logic ea, input logic [3:0] es, input logic er,
                       input logic xa, input logic xe,
                       input logic [15:0] sl, input logic [4:0] cnt);
    @(negedge clk);
    entry_req = e; exit_req = x; exit_slot = xs;
    expect_resp(ea, es, er, xa, xe, sl, cnt);
    @(negedge clk);
    entry_req = 1'b0; exit_req = 1'b0; exit_slot = 4'd0;
    if (ea) wait_gate_closed();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compare against the scoreboard whenever a response pulse is seen.
  exp_t mon_e;
  logic mon_pulse;
  always @(negedge clk) begin
    if (!rst) begin
      mon_pulse = entry_ack | entry_reject | exit_ack | exit_err;
      if (mon_pulse) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", {28'd0, entry_ack, entry_reject, exit_ack, exit_err}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("latency",      cyc,                      mon_e.cyc + 1);
          check("entry_ack",    {31'd0, entry_ack},       {31'd0, mon_e.ea});
          check("entry_slot",   {28'd0, entry_slot},      {28'd0, mon_e.es});
          check("entry_reject", {31'd0, entry_reject},    {31'd0, mon_e.er});
          check("exit_ack",     {31'd0, exit_ack},        {31'd0, mon_e.xa});
          check("exit_err",     {31'd0, exit_err},        {31'd0, mon_e.xe});
          check("slots",        {16'd0, slots},           {16'd0, mon_e.sl});
          check("count",        {27'd0, occupied_count},  {27'd0, mon_e.cnt});
          check("all_full",     {31'd0, all_full},        {31'd0, (mon_e.sl == 16'hFFFF)});
          check("any_free",     {31'd0, any_free},        {31'd0, (mon_e.sl != 16'hFFFF)});
        end
      end else if (sb_q.size() != 0 && cyc > sb_q[0].cyc) begin
        check("missing_response", {31'd0, mon_pulse}, 32'd1);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; entry_req = 1'b0; exit_req = 1'b0; exit_slot = 4'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_slots",      {16'd0, slots},          32'd0);
    check("rst_count",      {27'd0, occupied_count}, 32'd0);
    check("rst_all_full",   {31'd0, all_full},       32'd0);
    check("rst_any_free",   {31'd0, any_free},       32'd1);
    check("rst_gate",       {31'd0, gate_open},      32'd0);
    check("rst_entry_slot", {28'd0, entry_slot},     32'd0);
    check("rst_pulses", {28'd0, entry_ack, entry_reject, exit_ack, exit_err}, 32'd0);
    rst = 1'b0;

    // Held entry request: slot 0, four gate cycles, then re-accepted as slot 1.
    @(negedge clk);
    entry_req = 1'b1;
    expect_resp(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0001, 5'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("gate_open_held", {31'd0, gate_open}, 32'd1);
    end
    @(negedge clk);
    check("gate_closed_after_4", {31'd0, gate_open}, 32'd0);
    expect_resp(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0003, 5'd2);
    // Entry still held while OPEN: must be ignored (monitor flags any pulse).
    @(negedge clk);
    check("gate_open_second", {31'd0, gate_open}, 32'd1);
    @(negedge clk);
    entry_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midgate_rst_gate",     {31'd0, gate_open},      32'd0);
    check("midgate_rst_slots",    {16'd0, slots},          32'd0);
    check("midgate_rst_any_free", {31'd0, any_free},       32'd1);
    check("midgate_rst_count",    {27'd0, occupied_count}, 32'd0);
    rst = 1'b0;

    // Fill slots 0..15 in order, then a full-lot entry is rejected.
    for (int i = 0; i < 16; i++) begin
      issue(1'b1, 1'b0, 4'd0, 1'b1, 4'(i), 1'b0, 1'b0, 1'b0,
            16'((32'h1 << (i + 1)) - 32'h1), 5'(i + 1));
    end
    issue(1'b1, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 16'hFFFF, 5'd16);

    // Free slot 5 then re-allocate it.
    issue(1'b0, 1'b1, 4'd5, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0, 16'hFFDF, 5'd15);
    issue(1'b1, 1'b0, 4'd0, 1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 16'hFFFF, 5'd16);

    // Full lot with simultaneous entry and exit of slot 9.
    issue(1'b1, 1'b1, 4'd9, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 16'hFDFF, 5'd15);

    // Exit of an already free slot, then simultaneous entry and exit of slot 0.
    do_reset();
    issue(1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0001, 5'd1);
    issue(1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0001, 5'd1);
    issue(1'b1, 1'b1, 4'd0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 16'h0002, 5'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parking_slot_alloc16.md
Name: parking_slot_alloc16

Overview:
- Owns and updates the 16-slot occupancy map (bit i = 1 means slot i is occupied). The parking_status16 reporting logic only reads that map.
- Serves entry requests by allocating the lowest-index free slot and opening the entry gate for a fixed time.
- Serves exit requests by freeing the named slot.
- Drives the registered slots[15:0] map plus full/free/count status to downstream logic.

Parameters:
- GATE_CYCLES, 4, number of cycles gate_open stays high after a successful entry (legal range 1..255).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- entry_req  in  1  vehicle at entry; sampled only in state IDLE
- exit_req  in  1  vehicle leaving slot exit_slot
- exit_slot  in  4  slot index being vacated
- entry_ack  out  1  1-cycle pulse: slot allocated
- entry_slot  out  4  allocated index; valid while entry_ack=1, otherwise holds its last value
- entry_reject  out  1  1-cycle pulse: entry refused because the lot is full
- exit_ack  out  1  1-cycle pulse: slot freed
- exit_err  out  1  1-cycle pulse: exit_slot was already free; map unchanged
- gate_open  out  1  entry gate drive
- slots  out  16  registered occupancy map
- occupied_count  out  5  population count of slots (0..16)
- all_full  out  1  slots == 16'hFFFF
- any_free  out  1  ~all_full

Behaviour:
- Reset (rst=1 at a clock edge) has priority over all other inputs and values:
  - slots=0, occupied_count=0, all_full=0, any_free=1.
  - entry_ack=0, entry_reject=0, exit_ack=0, exit_err=0, gate_open=0, entry_slot=0.
  - FSM returns to IDLE; gate counter is cleared.
  - A reset asserted mid-gate drops gate_open on the next edge.
- Every output is registered. Each request gets its response on the edge after it is sampled, so latency is 1 cycle.
- all_full, any_free and occupied_count are derived from the same registered state as slots and update on the same edge.
- FSM states:
  - IDLE: gate_open=0; entry_req is sampled.
  - OPEN: gate_open=1; entry_req is ignored and produces no ack or reject; the request must be re-presented after the gate closes.
- Entry in IDLE, entry_req=1:
  - If any slot is free: set bit k, where k is the lowest index with slots[k]=0. Then entry_slot=k, entry_ack=1, go to OPEN, load counter=GATE_CYCLES.
  - If all 16 slots are occupied: entry_reject=1, stay in IDLE, map unchanged.
- OPEN: the counter decrements each cycle. The transition to IDLE takes effect on the edge where counter==1.
  - gate_open is high for exactly GATE_CYCLES cycles, starting the cycle after entry_ack's edge, i.e. the same cycle entry_ack is high.
  - entry_req can be accepted again on the edge after gate_open falls.
- Exit, exit_req=1, processed in every FSM state:
  - If slots[exit_slot]=1: clear the bit and pulse exit_ack.
  - If slots[exit_slot]=0: pulse exit_err and leave the map unchanged.
- Simultaneous entry and exit in the same cycle:
  - Allocation uses the pre-update map, so a slot freed in that cycle cannot be allocated in that cycle.
  - A full lot with a simultaneous valid exit rejects the entry; the exit still frees its slot.
  - The allocated bit and the freed bit are always distinct, because exit only acts on an occupied bit and entry only on a free bit. Both updates apply.
  - occupied_count gets the net change (+1−1 = 0).
- occupied_count range: it saturates naturally at 0 and 16, since an entry at 16 is rejected and an exit at 0 errors. It never wraps.
- Pulse outputs are high for exactly one cycle per sampled request.

Test Plan:
1. Reset, then hold entry_req=1 with GATE_CYCLES=4 -> entry_ack at slot 0, gate_open high 4 cycles. Re-accept after the gate closes, giving slot 1. Final state: slots=16'h0003, count=2.
2. Fill all 16 slots (slot indices 0..15 in order), then entry_req=1 -> entry_reject=1, slots=16'hFFFF, all_full=1, any_free=0, count=16.
3. From 16'hFFFF, exit_slot=5 -> exit_ack=1, slots=16'hFFDF. Next entry -> entry_slot=5, slots back to 16'hFFFF.
4. slots=16'h0001, exit_slot=3 -> exit_err=1, map unchanged, count=1.
5. Full lot, entry_req and exit_req (slot 9) in the same cycle -> entry_reject=1 and exit_ack=1, slots=16'hFDFF. In another case, slots=16'h0001 with entry and exit (slot 0) together -> entry_slot=1, slots=16'h0002, count unchanged at 1.
6. Assert rst during OPEN -> next edge gate_open=0, slots=0, any_free=1. An entry_req during OPEN (without reset) produces no ack and no reject.
